servo_seq_ctrl: RTL

//  Sequences the hobby-servo PWM stage: a rising edge on enable drives the servo from CLOSE to OPEN,

---
 rtl/servo_seq_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/servo_seq_ctrl.sv
// Servo open/hold/close sequencer with a built-in PWM generator.
// Build option: define SERVO_RAMP_EN to ramp the pulse width by PW_STEP each frame.
module servo_seq_ctrl #(
  parameter int unsigned FRAME_CYC   = 1_000_000,
  parameter int unsigned PW_CLOSE    = 50_000,
  parameter int unsigned PW_OPEN     = 100_000,
  parameter int unsigned PW_STEP     = 5_000,
  parameter int unsigned HOLD_FRAMES = 150,
  parameter int unsigned CNT_W       = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             force_close,
  output logic             servo,
  output logic             busy,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] pw_cur
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPENING = 2'd1,
    ST_HOLD    = 2'd2,
    ST_CLOSING = 2'd3
  } state_t;

`ifdef SERVO_RAMP_EN
  localparam int unsigned STEP = PW_STEP;
`else
  // One step larger than the whole travel, so every move saturates at its first boundary.
  localparam int unsigned STEP = FRAME_CYC + PW_STEP;
`endif

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYC - 32'd1);
  localparam logic [CNT_W-1:0] PW_CLOSE_C = CNT_W'(PW_CLOSE);
  localparam logic [CNT_W-1:0] PW_OPEN_C  = CNT_W'(PW_OPEN);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 32'd1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] pw_cur_q, pw_cur_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             enable_dly_q, enable_dly_d;
  logic             servo_q, servo_d;
  logic             busy_q, busy_d;

  logic        boundary_s, en_rise_s;
  logic        fc_evt_s, open_evt_s, rehold_evt_s;
  logic [31:0] pw_wide_s, up_sum_s;
  logic        up_sat_s, dn_sat_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= '0;
      pw_cur_q     <= PW_CLOSE_C;
      hold_cnt_q   <= '0;
      enable_dly_q <= 1'b0;
      servo_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      pw_cur_q     <= pw_cur_d;
      hold_cnt_q   <= hold_cnt_d;
      enable_dly_q <= enable_dly_d;
      servo_q      <= servo_d;
      busy_q       <= busy_d;
    end
  end

  // Saturation limits are tested in 32 bits so the CNT_W registers never wrap.
  always_comb begin
    boundary_s   = (frame_cnt_q == FRAME_LAST);
    en_rise_s    = enable & ~enable_dly_q;
    fc_evt_s     = force_close & ((state_q == ST_OPENING) | (state_q == ST_HOLD));
    open_evt_s   = en_rise_s & ((state_q == ST_IDLE) |
                                ((state_q == ST_CLOSING) & ~force_close));
    rehold_evt_s = en_rise_s & (state_q == ST_HOLD);
    pw_wide_s    = 32'(pw_cur_q);
    up_sum_s     = pw_wide_s + STEP;
    up_sat_s     = (up_sum_s >= PW_OPEN);
    dn_sat_s     = (pw_wide_s <= (PW_CLOSE + STEP));
  end

  // Next-state, pulse-width and counter logic; events override boundary ramping.
  always_comb begin
    state_d      = state_q;
    pw_cur_d     = pw_cur_q;
    hold_cnt_d   = hold_cnt_q;
    enable_dly_d = enable;
    servo_d      = (frame_cnt_q < pw_cur_q);
    if (boundary_s) begin
      frame_cnt_d = '0;
    end else begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end

    if (fc_evt_s) begin
      state_d = ST_CLOSING;
    end else if (open_evt_s) begin
      state_d = ST_OPENING;
    end else if (rehold_evt_s) begin
      hold_cnt_d = '0;
    end else if (boundary_s) begin
      case (state_q)
        ST_OPENING: begin
          if (up_sat_s) begin
            pw_cur_d   = PW_OPEN_C;
            hold_cnt_d = '0;
            state_d    = ST_HOLD;
          end else begin
            pw_cur_d = CNT_W'(up_sum_s);
          end
        end
        ST_HOLD, ST_CLOSING: begin
          if ((state_q == ST_HOLD) && (hold_cnt_q != HOLD_LAST)) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end else if (dn_sat_s) begin
            pw_cur_d = PW_CLOSE_C;
            state_d  = ST_IDLE;
          end else begin
            pw_cur_d = pw_cur_q - CNT_W'(STEP);
            state_d  = ST_CLOSING;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign servo  = servo_q;
  assign busy   = busy_q;
  assign state  = state_q;
  assign pw_cur = pw_cur_q;

endmodule
